// File: rtl/stack_exec_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_exec_unit_if : decoder, stack and data-memory signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface stack_exec_unit_if #(
  parameter int DATA_LEN = 16,
  parameter int ADDR_LEN = 8,
  parameter int INST_CAP = 32
);
  localparam int PC_W = $clog2(INST_CAP) + 1;

  logic                en;
  logic [3:0]          opcode;
  logic [ADDR_LEN-1:0] addr_const;
  logic [DATA_LEN-1:0] stk_data_out;
  logic                stk_empty;
  logic                stk_full;
  logic [DATA_LEN-1:0] stk_data_in;
  logic                stk_push;
  logic                stk_pop;
  logic [DATA_LEN-1:0] mem_data_out;
  logic [DATA_LEN-1:0] mem_data_in;
  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_r_en;
  logic                mem_w_en;
  logic [PC_W-1:0]     pc;
  logic                busy;
  logic                fin_sig;
  logic                err;

  modport slave (
    input  en, opcode, addr_const, stk_data_out, stk_empty, stk_full, mem_data_out,
    output stk_data_in, stk_push, stk_pop, mem_data_in, mem_addr, mem_r_en, mem_w_en,
           pc, busy, fin_sig, err
  );

  modport master (
    output en, opcode, addr_const, stk_data_out, stk_empty, stk_full, mem_data_out,
    input  stk_data_in, stk_push, stk_pop, mem_data_in, mem_addr, mem_r_en, mem_w_en,
           pc, busy, fin_sig, err
  );
endinterface
`default_nettype wire

// File: rtl/stack_exec_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_exec_unit : FSM execute engine (ALU, push/pop, PC) for the stack CPU.
// Optional stack guards enabled by macro STACK_GUARD_EN.   Rev 1.0
// ----------------------------------------------------------------------------
module stack_exec_unit #(
  parameter int DATA_LEN = 16,
  parameter int ADDR_LEN = 8,
  parameter int INST_CAP = 32
) (
  input  logic             clk,
  input  logic             rstn,
  stack_exec_unit_if.slave bus
);
  localparam int              PC_W   = $clog2(INST_CAP) + 1;
  localparam logic [PC_W-1:0] c_CAP  = PC_W'(INST_CAP);
  localparam logic [PC_W-1:0] c_LAST = PC_W'(INST_CAP - 1);

  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_ADD  = 4'h1;
  localparam logic [3:0] c_OP_SUB  = 4'h2;
  localparam logic [3:0] c_OP_AND  = 4'h3;
  localparam logic [3:0] c_OP_OR   = 4'h4;
  localparam logic [3:0] c_OP_XOR  = 4'h5;
  localparam logic [3:0] c_OP_NOT  = 4'h6;
  localparam logic [3:0] c_OP_PSH  = 4'h7;
  localparam logic [3:0] c_OP_POP  = 4'h8;
  localparam logic [3:0] c_OP_JMP  = 4'h9;
  localparam logic [3:0] c_OP_JZ   = 4'hA;
  localparam logic [3:0] c_OP_JS   = 4'hB;
  localparam logic [3:0] c_OP_DUP  = 4'hC;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE, S_POPA, S_POPB, S_CAPB, S_ALU, S_PUSH, S_PUSH2,
    S_MRD, S_MCAP, S_MWR, S_DONE, S_HALT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt, w_pc_inc, w_tgt_raw, w_tgt;
  logic                r_z, r_s, r_err, w_err_set, w_jmp_take, w_tgt_oor;
  logic [3:0]          r_op;
  logic [ADDR_LEN-1:0] r_addr;
  logic [DATA_LEN-1:0] r_a, r_b, w_result;
  logic                w_binop, w_blk_pop, w_blk_push, w_pop, w_push;

`ifdef STACK_GUARD_EN
  assign w_blk_pop  = bus.stk_empty;
  assign w_blk_push = bus.stk_full;
`else
  logic w_unused_guard;
  assign w_blk_pop      = 1'b0;
  assign w_blk_push     = 1'b0;
  assign w_unused_guard = bus.stk_empty ^ bus.stk_full;
`endif

  assign w_binop    = (r_op >= c_OP_ADD) && (r_op <= c_OP_XOR);
  assign w_pc_inc   = (r_pc == c_LAST) ? '0 : r_pc + PC_W'(1);
  assign w_tgt_raw  = bus.addr_const[PC_W-1:0];
  assign w_tgt_oor  = (w_tgt_raw >= c_CAP);
  assign w_tgt      = w_tgt_oor ? (w_tgt_raw % c_CAP) : w_tgt_raw;
  // Jump decisions are made on the en-sample edge, so they look at the live opcode.
  assign w_jmp_take = (bus.opcode == c_OP_JMP) ||
                      ((bus.opcode == c_OP_JZ) && r_z) ||
                      ((bus.opcode == c_OP_JS) && r_s);

  assign w_pop  = ((r_state == S_POPA) || (r_state == S_POPB)) && !w_blk_pop;
  assign w_push = ((r_state == S_PUSH) || (r_state == S_PUSH2)) && !w_blk_push;

  always_comb begin
    w_result = r_a;
    case (r_op)
      c_OP_ADD: w_result = r_b + r_a;
      c_OP_SUB: w_result = r_b - r_a;
      c_OP_AND: w_result = r_b & r_a;
      c_OP_OR:  w_result = r_b | r_a;
      c_OP_XOR: w_result = r_b ^ r_a;
      c_OP_NOT: w_result = ~r_a;
      default:  w_result = r_a;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en) begin
          case (bus.opcode)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR,
            c_OP_NOT, c_OP_DUP, c_OP_POP: w_state_nxt = S_POPA;
            c_OP_PSH:                     w_state_nxt = S_MRD;
            c_OP_NOP: begin
              w_state_nxt = S_DONE;
              w_pc_nxt    = w_pc_inc;
            end
            c_OP_JMP, c_OP_JZ, c_OP_JS: begin
              w_state_nxt = S_DONE;
              w_pc_nxt    = w_jmp_take ? w_tgt : w_pc_inc;
              w_err_set   = w_jmp_take && w_tgt_oor;
            end
            c_OP_HALT: w_state_nxt = S_DONE;
            default: begin
              w_state_nxt = S_DONE;
              w_pc_nxt    = w_pc_inc;
              w_err_set   = 1'b1;
            end
          endcase
        end
      end
      S_POPA: begin
        if (w_blk_pop) begin
          w_state_nxt = S_DONE;
          w_err_set   = 1'b1;
        end else if (w_binop) begin
          w_state_nxt = S_POPB;
        end else if ((r_op == c_OP_NOT) || (r_op == c_OP_DUP)) begin
          w_state_nxt = S_CAPB;
        end else begin
          w_state_nxt = S_MCAP;
        end
      end
      S_POPB: begin
        w_state_nxt = w_blk_pop ? S_DONE : S_CAPB;
        w_err_set   = w_blk_pop;
      end
      S_CAPB: w_state_nxt = S_PUSH;
      S_PUSH, S_PUSH2: begin
        if (w_blk_push) begin
          w_state_nxt = S_DONE;
          w_err_set   = 1'b1;
        end else if ((r_state == S_PUSH) && (r_op == c_OP_DUP)) begin
          w_state_nxt = S_PUSH2;
        end else begin
          w_state_nxt = S_DONE;
          w_pc_nxt    = w_pc_inc;
        end
      end
      S_MRD:  w_state_nxt = S_MCAP;
      S_MCAP: w_state_nxt = (r_op == c_OP_PSH) ? S_PUSH : S_MWR;
      S_MWR: begin
        w_state_nxt = S_DONE;
        w_pc_nxt    = w_pc_inc;
      end
      S_DONE: w_state_nxt = (r_op == c_OP_HALT) ? S_HALT : S_IDLE;
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_z     <= 1'b0;
      r_s     <= 1'b0;
      r_err   <= 1'b0;
      r_op    <= '0;
      r_addr  <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_err_set) r_err <= 1'b1;
      if ((r_state == S_IDLE) && bus.en) begin
        r_op   <= bus.opcode;
        r_addr <= bus.addr_const;
      end
      // Stack/memory read data arrives one cycle after its strobe.
      case (r_state)
        S_POPB: r_a <= bus.stk_data_out;
        S_CAPB: begin
          if (w_binop) r_b <= bus.stk_data_out;
          else         r_a <= bus.stk_data_out;
        end
        S_MCAP: r_a <= (r_op == c_OP_PSH) ? bus.mem_data_out : bus.stk_data_out;
        S_PUSH: begin
          if (w_push && (w_binop || (r_op == c_OP_NOT))) begin
            r_z <= (w_result == '0);
            r_s <= w_result[DATA_LEN-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stk_pop     = w_pop;
  assign bus.stk_push    = w_push;
  assign bus.stk_data_in = w_push ? w_result : '0;
  assign bus.mem_r_en    = (r_state == S_MRD);
  assign bus.mem_w_en    = (r_state == S_MWR);
  assign bus.mem_addr    = ((r_state == S_MRD) || (r_state == S_MWR)) ? r_addr : '0;
  assign bus.mem_data_in = (r_state == S_MWR) ? r_a : '0;
  assign bus.pc          = r_pc;
  assign bus.busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign bus.fin_sig     = (r_state == S_DONE);
  assign bus.err         = r_err;
endmodule
`default_nettype wire

// File: tb/tb_stack_exec_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stack_exec_unit : randomized bench with an instruction-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stack_exec_unit;
  localparam int DATA_LEN = 16;
  localparam int ADDR_LEN = 8;
  localparam int INST_CAP = 32;
  localparam int PC_W     = $clog2(INST_CAP) + 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  stack_exec_unit_if #(.DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN), .INST_CAP(INST_CAP)) bus ();
  stack_exec_unit #(.DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN), .INST_CAP(INST_CAP)) dut (
    .clk(clk), .rstn(rstn), .bus(bus));

  int n_vec  = 0;
  int n_miss = 0;
  int n_inst = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // External stack and data memory driven by the DUT strobes
  logic [15:0] env_stk[$];
  logic [15:0] env_mem[256];
  always @(posedge clk) begin
    if (bus.stk_pop) begin
      if (env_stk.size() > 0) bus.stk_data_out <= env_stk.pop_back();
      else                    bus.stk_data_out <= 16'h0;
    end
    if (bus.stk_push) env_stk.push_back(bus.stk_data_in);
    if (bus.mem_r_en) bus.mem_data_out <= env_mem[bus.mem_addr];
    if (bus.mem_w_en) env_mem[bus.mem_addr] = bus.mem_data_in;
    bus.stk_empty <= (env_stk.size() == 0);
    bus.stk_full  <= (env_stk.size() >= 16);
  end

  // Reference model: architectural state only
  logic [15:0] ref_stk[$];
  logic [15:0] ref_mem[256];
  int ref_pc;
  bit ref_z, ref_s, ref_err;

  function automatic logic [15:0] rpop();
    logic [15:0] v;
    v = 16'h0;
    if (ref_stk.size() > 0) v = ref_stk.pop_back();
    return v;
  endfunction

  task automatic ref_reset();
    ref_pc = 0; ref_z = 0; ref_s = 0; ref_err = 0;
  endtask

  task automatic clear_stacks();
    env_stk.delete();
    ref_stk.delete();
    bus.stk_empty <= 1'b1;
    bus.stk_full  <= 1'b0;
  endtask

  task automatic push_both(input logic [15:0] v);
    env_stk.push_back(v);
    ref_stk.push_back(v);
    bus.stk_empty <= 1'b0;
  endtask

  // Observed activity of one instruction window
  int m_fin_cyc, m_fin_n, m_pops, m_first_push, m_mr_cyc, m_mr_n, m_mr_addr;
  int m_mw_n, m_mw_addr, m_mw_data, m_ovl, m_pc_fin;
  logic [15:0] m_push_q[$];

  task automatic observe(input int maxc, input bit stop_on_fin);
    m_fin_cyc = 0; m_fin_n = 0; m_pops = 0; m_first_push = 0; m_mr_cyc = 0; m_mr_n = 0;
    m_mr_addr = 0; m_mw_n = 0; m_mw_addr = 0; m_mw_data = 0; m_ovl = 0; m_pc_fin = 0;
    m_push_q.delete();
    for (int cyc = 1; cyc <= maxc; cyc++) begin
      @(negedge clk);
      if (bus.fin_sig) begin
        m_fin_n++;
        if (m_fin_cyc == 0) begin
          m_fin_cyc = cyc;
          m_pc_fin  = int'(bus.pc);
        end
      end
      if (bus.stk_pop) m_pops++;
      if (bus.stk_push) begin
        if (m_push_q.size() == 0) m_first_push = cyc;
        m_push_q.push_back(bus.stk_data_in);
      end
      if (bus.stk_pop && bus.stk_push) m_ovl++;
      if (bus.mem_r_en) begin
        m_mr_n++; m_mr_cyc = cyc; m_mr_addr = int'(bus.mem_addr);
      end
      if (bus.mem_w_en) begin
        m_mw_n++; m_mw_addr = int'(bus.mem_addr); m_mw_data = int'(bus.mem_data_in);
      end
      if (stop_on_fin && (m_fin_cyc != 0) && (cyc > m_fin_cyc)) break;
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [7:0] ad);
    @(negedge clk);
    bus.en = 1'b1; bus.opcode = op; bus.addr_const = ad;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [7:0] ad);
    int e_fin, e_pops, e_fp, e_pc, e_mr, e_mw, e_mwd;
    logic [15:0] e_push[$];
    logic [15:0] a, b, r;
    bit take;
    string t;
    e_fin = 1; e_pops = 0; e_fp = 0; e_mr = 0; e_mw = 0; e_mwd = 0;
    a = 16'h0; b = 16'h0; r = 16'h0;
    e_pc = (ref_pc + 1) % INST_CAP;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        a = rpop(); b = rpop();
        case (op)
          4'h1:    r = b + a;
          4'h2:    r = b - a;
          4'h3:    r = b & a;
          4'h4:    r = b | a;
          default: r = b ^ a;
        endcase
        e_push.push_back(r); ref_stk.push_back(r);
        ref_z = (r == 16'h0); ref_s = r[15];
        e_fin = 5; e_pops = 2; e_fp = 4;
      end
      4'h6: begin
        a = rpop(); r = ~a;
        e_push.push_back(r); ref_stk.push_back(r);
        ref_z = (r == 16'h0); ref_s = r[15];
        e_fin = 4; e_pops = 1; e_fp = 3;
      end
      4'hC: begin
        a = rpop();
        e_push.push_back(a); e_push.push_back(a);
        ref_stk.push_back(a); ref_stk.push_back(a);
        e_fin = 5; e_pops = 1; e_fp = 3;
      end
      4'h7: begin
        r = ref_mem[ad];
        e_push.push_back(r); ref_stk.push_back(r);
        e_fin = 4; e_fp = 3; e_mr = 1;
      end
      4'h8: begin
        a = rpop(); ref_mem[ad] = a;
        e_fin = 4; e_pops = 1; e_mw = 1; e_mwd = int'(a);
      end
      4'h9, 4'hA, 4'hB: begin
        take = (op == 4'h9) || ((op == 4'hA) && ref_z) || ((op == 4'hB) && ref_s);
        if (take) begin
          e_pc = int'(ad[PC_W-1:0]) % INST_CAP;
          if (int'(ad[PC_W-1:0]) >= INST_CAP) ref_err = 1;
        end
      end
      4'hF: e_pc = ref_pc;
      4'h0: ;
      default: ref_err = 1;
    endcase
    ref_pc = e_pc;
    n_inst++;
    launch(op, ad);
    observe(12, 1'b1);
    t = $sformatf("i%0d_op%0h", n_inst, op);
    chk({t, "_fin"}, m_fin_cyc, e_fin);
    chk({t, "_pc"}, m_pc_fin, e_pc);
    chk({t, "_busy_after"}, int'(bus.busy), 0);
    chk({t, "_pops"}, m_pops, e_pops);
    chk({t, "_npush"}, m_push_q.size(), e_push.size());
    for (int i = 0; i < e_push.size() && i < m_push_q.size(); i++)
      chk($sformatf("%s_push%0d", t, i), int'(m_push_q[i]), int'(e_push[i]));
    chk({t, "_push_cyc"}, m_first_push, e_fp);
    chk({t, "_mrd"}, m_mr_n * 16 + m_mr_cyc, e_mr * 17);
    if (e_mr != 0) chk({t, "_mrd_addr"}, m_mr_addr, int'(ad));
    chk({t, "_mwr"}, m_mw_n, e_mw);
    if (e_mw != 0) begin
      chk({t, "_mwr_addr"}, m_mw_addr, int'(ad));
      chk({t, "_mwr_data"}, m_mw_data, e_mwd);
    end
    chk({t, "_err"}, int'(bus.err), int'(ref_err));
    chk({t, "_overlap"}, m_ovl, 0);
    chk({t, "_depth"}, env_stk.size(), ref_stk.size());
  endtask

  task automatic random_instr();
    logic [3:0] op;
    int d;
    bit ok;
    do begin
      op = 4'($urandom_range(0, 14));
      d  = ref_stk.size();
      ok = 1'b1;
      if ((op inside {[4'h1:4'h5]}) && (d < 2)) ok = 1'b0;
      if ((op inside {4'h6, 4'h8, 4'hC}) && (d < 1)) ok = 1'b0;
      if ((op inside {4'h7, 4'hC}) && (d >= 12)) ok = 1'b0;
    end while (!ok);
    run_instr(op, 8'($urandom));
  endtask

  task automatic check_reset(input string t);
    chk({t, "_pc"}, int'(bus.pc), 0);
    chk({t, "_busy"}, int'(bus.busy), 0);
    chk({t, "_fin"}, int'(bus.fin_sig), 0);
    chk({t, "_err"}, int'(bus.err), 0);
    chk({t, "_strobes"}, int'({bus.stk_push, bus.stk_pop, bus.mem_r_en, bus.mem_w_en}), 0);
    chk({t, "_data"}, int'(bus.stk_data_in) + int'(bus.mem_data_in) + int'(bus.mem_addr), 0);
  endtask

  task automatic do_reset(input string t);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset(t);
    rstn = 1'b1;
    ref_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int pc_h;
    bus.en = 1'b0; bus.opcode = 4'h0; bus.addr_const = 8'h0;
    bus.stk_data_out <= 16'h0; bus.mem_data_out <= 16'h0;
    bus.stk_empty <= 1'b1; bus.stk_full <= 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    ref_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rstn = 1'b1;

    run_instr(4'h0, 8'h00);
    chk("nop_pc", int'(bus.pc), 1);

    clear_stacks(); push_both(16'd5); push_both(16'd3);
    run_instr(4'h2, 8'h00);
    chk("sub_value", (m_push_q.size() > 0) ? int'(m_push_q[0]) : -1, 2);
    clear_stacks(); push_both(16'd5); push_both(16'd5);
    run_instr(4'h2, 8'h00);
    run_instr(4'hA, 8'h07);
    chk("jz_pc", int'(bus.pc), 7);

    env_mem[16] = 16'hABCD; ref_mem[16] = 16'hABCD;
    run_instr(4'h7, 8'h10);
    run_instr(4'h8, 8'h20);
    chk("pop_mem20", int'(env_mem[32]), 16'hABCD);

    run_instr(4'h9, 8'd31);
    push_both(16'h1234); push_both(16'h0001);
    run_instr(4'h1, 8'h00);
    chk("wrap_pc", int'(bus.pc), 0);

    repeat (80) random_instr();

    run_instr(4'h9, 8'h25);
    chk("oor_pc", int'(bus.pc), 5);
    chk("oor_err", int'(bus.err), 1);

    run_instr(4'hF, 8'h00);
    pc_h = ref_pc;
    repeat (3) begin
      launch(4'h0, 8'h00);
      observe(4, 1'b0);
      chk("halt_fin", m_fin_n, 0);
      chk("halt_pc", int'(bus.pc), pc_h);
      chk("halt_busy", int'(bus.busy), 0);
    end
    do_reset("rst_halt");
    run_instr(4'h0, 8'h00);

    clear_stacks(); push_both(16'd7); push_both(16'd9);
    launch(4'h1, 8'h00);
    @(negedge clk);
    chk("mid_popa", int'(bus.stk_pop), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_strobes", int'({bus.stk_push, bus.stk_pop, bus.mem_r_en, bus.mem_w_en}), 0);
    chk("mid_busy", int'(bus.busy), 0);
    rstn = 1'b1;
    ref_reset();
    observe(6, 1'b0);
    chk("mid_no_push", m_push_q.size(), 0);
    chk("mid_no_fin", m_fin_n, 0);
    chk("mid_pc", int'(bus.pc), 0);

    clear_stacks();
`ifdef STACK_GUARD_EN
    pc_h = ref_pc;
    launch(4'h1, 8'h00);
    observe(8, 1'b1);
    chk("guard_pops", m_pops, 0);
    chk("guard_fin", m_fin_n, 1);
    chk("guard_pc", m_pc_fin, pc_h);
    chk("guard_err", int'(bus.err), 1);
    chk("guard_push", m_push_q.size(), 0);
    ref_err = 1;
`else
    run_instr(4'h1, 8'h00);
    chk("noguard_pops", m_pops, 2);
    chk("noguard_err", int'(bus.err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
